// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and default limits for the data-RAM arbiter.
//   arb_state_t   : IDLE (CPU priority) / DMA_BURST (DMA holds the port)
//   owner_t       : which requester drives RAM port A this cycle
//   *_DEF         : default burst length and starvation limit
package dmem_arb_pkg;
   typedef enum logic {IDLE, DMA_BURST} arb_state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t;
   localparam int MAX_BURST_DEF  = 16;
   localparam int STARVE_LIM_DEF = 4;
   localparam int CPU_ADDR_W     = 16;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, DMA and RAM port-A signals around the arbiter.
//   CPU side : halt, cpu_req/we/addr/wdata in; cpu_stall/rvalid/rdata out
//   DMA side : dma_req/addr/wdata/last in; dma_ack out
//   RAM side : mem_addr/wdata/ren/wren out; mem_q in
//   slave    : the arbiter's view; master : the surrounding system's view
interface dmem_arbiter_if
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 16
);
   logic                  halt;
   logic                  cpu_req;
   logic                  cpu_we;
   logic [CPU_ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0]     cpu_wdata;
   logic                  cpu_stall;
   logic                  cpu_rvalid;
   logic [DATA_W-1:0]     cpu_rdata;
   logic                  dma_req;
   logic [ADDR_W-1:0]     dma_addr;
   logic [DATA_W-1:0]     dma_wdata;
   logic                  dma_last;
   logic                  dma_ack;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic                  mem_ren;
   logic                  mem_wren;
   logic [DATA_W-1:0]     mem_q;

   modport slave (
      input  halt, cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  dma_req, dma_addr, dma_wdata, dma_last, mem_q,
      output cpu_stall, cpu_rvalid, cpu_rdata, dma_ack,
      output mem_addr, mem_wdata, mem_ren, mem_wren
   );

   modport master (
      output halt, cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output dma_req, dma_addr, dma_wdata, dma_last, mem_q,
      input  cpu_stall, cpu_rvalid, cpu_rdata, dma_ack,
      input  mem_addr, mem_wdata, mem_ren, mem_wren
   );
endinterface

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: saturating up-counter with synchronous clear and a limit flag.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : count one event (ignored once the limit is reached)
//   clr      : return to zero; wins over inc
//   at_lim   : count equals LIM
module arb_starve_ctr #(
   parameter int LIM = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic at_lim
);
   localparam int W = (LIM < 1) ? 1 : $clog2(LIM + 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc && !at_lim)
         cnt <= cnt + 1'b1;
   end

   assign at_lim = cnt == W'(LIM);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-ported data RAM port A between the CPU and the CCD DMA writer.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : CPU request/stall/read-return, DMA beat/ack, RAM port-A drive
// The CPU wins by default; a DMA denied STARVE_LIM consecutive cycles is promoted
// and then keeps the port for up to MAX_BURST beats.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W     = 11,
   parameter int DATA_W     = 16,
   parameter int MAX_BURST  = MAX_BURST_DEF,
   parameter int STARVE_LIM = STARVE_LIM_DEF
) (
   input  logic           clk,
   input  logic           rst,
   dmem_arbiter_if.slave  bus
);
   arb_state_t state, state_nxt;
   owner_t     own;
   logic       starve_lim;
   logic       beat_lim;
   logic       cpu_gnt;
   logic       dma_gnt;
   logic       rel;
   logic       rd_pend;
   logic       unused_addr;

   // Upper CPU address bits alias onto the RAM.
   assign unused_addr = ^bus.cpu_addr[CPU_ADDR_W-1:ADDR_W];

   // Grant mux; reset forces no owner so an in-flight beat is never written.
   always_comb begin
      own = OWN_NONE;
      if (!rst) begin
         if (state == DMA_BURST)
            own = bus.dma_req ? OWN_DMA : OWN_NONE;
         else
            own = (starve_lim && bus.dma_req) ? OWN_DMA :
                  bus.cpu_req                 ? OWN_CPU :
                  bus.dma_req                 ? OWN_DMA : OWN_NONE;
      end
   end

   assign cpu_gnt = own == OWN_CPU;
   assign dma_gnt = own == OWN_DMA;
   // Burst ends on the marked last beat or on the beat that reaches MAX_BURST.
   assign rel     = dma_gnt && (bus.dma_last || beat_lim);

   arb_starve_ctr #(.LIM(STARVE_LIM)) u_starve (
      .clk    (clk),
      .rst    (rst),
      .inc    (cpu_gnt && bus.dma_req),
      .clr    (dma_gnt || !bus.dma_req),
      .at_lim (starve_lim)
   );

   // Limit is one below MAX_BURST: the flag marks that the next ack is the final one.
   arb_starve_ctr #(.LIM(MAX_BURST - 1)) u_beat (
      .clk    (clk),
      .rst    (rst),
      .inc    (dma_gnt),
      .clr    (rel),
      .at_lim (beat_lim)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      bus.cpu_stall = bus.cpu_req && !cpu_gnt;
      bus.dma_ack   = dma_gnt;
      bus.mem_ren   = cpu_gnt && !bus.cpu_we;
      bus.mem_wren  = !bus.halt && (dma_gnt || (cpu_gnt && bus.cpu_we));
      bus.mem_addr  = dma_gnt ? bus.dma_addr  : cpu_gnt ? bus.cpu_addr[ADDR_W-1:0] : '0;
      bus.mem_wdata = dma_gnt ? bus.dma_wdata : cpu_gnt ? bus.cpu_wdata : '0;
      if (dma_gnt)
         state_nxt = rel ? IDLE : DMA_BURST;
   end

   // Read return tracks the granted load only, independent of arbiter state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rd_pend <= 1'b0;
      else
         rd_pend <= cpu_gnt && !bus.cpu_we;
   end

   assign bus.cpu_rvalid = rd_pend;
   assign bus.cpu_rdata  = bus.mem_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a RAM model and a
// cycle-level reference model of the arbitration rules.
//   clk, rst : generated here; bus : interface instance shared with the DUT
module tb_dmem_arbiter;
   localparam int AW     = 11;
   localparam int DW     = 16;
   localparam int MAXB   = 16;
   localparam int STARVE = 4;
   localparam int NONE = 0, CPU = 1, DMA = 2;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAXB), .STARVE_LIM(STARVE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // RAM port A: registered read, synchronous write.
   logic [DW-1:0] ram [2048];
   always @(posedge clk) begin
      if (bus.mem_ren) bus.mem_q <= ram[bus.mem_addr];
      if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_wdata;
   end

   function automatic logic [DW-1:0] init_val(int i);
      return 16'(i * 7 + 'h1000);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: denied-DMA streak, burst flag and beat count as integers,
   // plus a shadow memory fed by the writes the rules say must happen.
   int            streak = 0;
   int            beats = 0;
   bit            burst = 0;
   bit            rv = 0;
   logic [DW-1:0] erd = '0;
   logic [DW-1:0] mm [2048];

   function automatic int own_now();
      if (rst) return NONE;
      if (burst) return bus.dma_req ? DMA : NONE;
      if (streak >= STARVE && bus.dma_req) return DMA;
      if (bus.cpu_req) return CPU;
      if (bus.dma_req) return DMA;
      return NONE;
   endfunction

   always @(posedge clk or posedge rst) begin
      int o;
      if (rst) begin
         streak = 0;
         beats  = 0;
         burst  = 0;
         rv     = 0;
      end else begin
         o   = own_now();
         rv  = (o == CPU) && !bus.cpu_we;
         erd = mm[bus.cpu_addr[AW-1:0]];
         if (!bus.halt && o == DMA) mm[bus.dma_addr] = bus.dma_wdata;
         if (!bus.halt && o == CPU && bus.cpu_we) mm[bus.cpu_addr[AW-1:0]] = bus.cpu_wdata;
         if (o == DMA) begin
            streak = 0;
            beats++;
            if (bus.dma_last || beats == MAXB) begin
               burst = 0;
               beats = 0;
            end else
               burst = 1;
         end else if (!bus.dma_req)
            streak = 0;
         else if (!burst && o == CPU && streak < STARVE)
            streak++;
      end
   end

   always @(negedge clk) begin
      int o;
      o = own_now();
      chk("stall", bus.cpu_stall, bus.cpu_req && o != CPU);
      chk("ack", bus.dma_ack, o == DMA);
      chk("ren", bus.mem_ren, o == CPU && !bus.cpu_we);
      chk("wren", bus.mem_wren, !bus.halt && (o == DMA || (o == CPU && bus.cpu_we)));
      chk("rvalid", bus.cpu_rvalid, rv);
      if (rv && !rst) chk("rdata", bus.cpu_rdata, erd);
      if (o == DMA) chk("addr_dma", bus.mem_addr, bus.dma_addr);
      if (o == CPU) chk("addr_cpu", bus.mem_addr, bus.cpu_addr[AW-1:0]);
      if (o == DMA) chk("wdata_dma", bus.mem_wdata, bus.dma_wdata);
      if (o == CPU && bus.cpu_we) chk("wdata_cpu", bus.mem_wdata, bus.cpu_wdata);
   end

   initial begin
      int k, run, first_run, gc, nrv, g;
      bit cpu_pend;
      rst = 1'b1;
      bus.halt = 0; bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.dma_req = 0; bus.dma_addr = '0; bus.dma_wdata = '0; bus.dma_last = 0;
      for (int i = 0; i < 2048; i++) begin
         ram[i] <= init_val(i);
         mm[i] = init_val(i);
      end
      ram[11'h123] <= 16'hBEEF;
      mm[11'h123] = 16'hBEEF;

      // Reset state
      @(negedge clk);
      chk("rst_stall", bus.cpu_stall, 0);
      chk("rst_ack", bus.dma_ack, 0);
      chk("rst_ren", bus.mem_ren, 0);
      chk("rst_wren", bus.mem_wren, 0);
      chk("rst_rvalid", bus.cpu_rvalid, 0);
      chk("rst_addr", bus.mem_addr, 0);
      bus.cpu_req = 1;
      #1 chk("rst_stall_req", bus.cpu_stall, 1);
      bus.cpu_req = 0;
      step();
      rst = 1'b0;

      // Single load, then reset clears a pending read return
      bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0123;
      @(negedge clk);
      chk("ld_ren", bus.mem_ren, 1);
      chk("ld_stall", bus.cpu_stall, 0);
      chk("ld_addr", bus.mem_addr, 'h123);
      step();
      bus.cpu_req = 0;
      @(negedge clk);
      chk("ld_rvalid", bus.cpu_rvalid, 1);
      chk("ld_rdata", bus.cpu_rdata, 16'hBEEF);
      #1 rst = 1'b1;
      #1 chk("rst_rvalid_clear", bus.cpu_rvalid, 0);
      step();
      rst = 1'b0;

      // Back-to-back loads
      nrv = 0;
      for (int i = 0; i < 4; i++) begin
         bus.cpu_req = i < 3; bus.cpu_we = 0; bus.cpu_addr = 16'h0020 + 16'(i);
         @(negedge clk);
         nrv += int'(bus.cpu_rvalid);
         step();
      end
      chk("b2b_rvalid_count", nrv, 3);

      // Starvation promotes the DMA on the fifth contended cycle
      g = 0;
      for (int i = 0; i < 6; i++) begin
         bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0100 + 16'(g);
         bus.dma_req = 1; bus.dma_addr = 11'h200; bus.dma_wdata = 16'h1111; bus.dma_last = 1;
         @(negedge clk);
         chk("starve_ack", bus.dma_ack, i == 4);
         chk("starve_stall", bus.cpu_stall, i == 4);
         if (!bus.cpu_stall) g++;
         step();
      end
      bus.cpu_req = 0; bus.dma_req = 0; bus.dma_last = 0;

      // 20-beat burst: forced release after 16, CPU slips in, DMA resumes
      k = 0; run = 0; first_run = -1; gc = -1; cpu_pend = 0;
      for (int c = 0; c < 40 && k < 20; c++) begin
         if (c == 1) cpu_pend = 1;
         bus.dma_req = 1; bus.dma_addr = 11'h400 + 11'(k); bus.dma_wdata = 16'hD000 + 16'(k);
         bus.dma_last = k == 19;
         bus.cpu_req = cpu_pend; bus.cpu_we = 1; bus.cpu_addr = 16'h0300; bus.cpu_wdata = 16'h7777;
         @(negedge clk);
         if (bus.dma_ack) begin
            k++;
            if (first_run < 0) run++;
         end else if (first_run < 0)
            first_run = run;
         if (cpu_pend && !bus.cpu_stall) begin
            cpu_pend = 0;
            gc = c;
         end
         step();
      end
      bus.dma_req = 0; bus.cpu_req = 0; bus.dma_last = 0;
      chk("burst_first_run", first_run, 16);
      chk("burst_cpu_cycle", gc, 16);
      chk("burst_beats", k, 20);
      @(negedge clk);
      chk("burst_ram_b16", ram[11'h40F], 16'hD00F);
      chk("burst_ram_b20", ram[11'h413], 16'hD013);
      chk("burst_ram_cpu", ram[11'h300], 16'h7777);
      step();

      // halt drops writes but grants and acks proceed
      bus.halt = 1; bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'h0010; bus.cpu_wdata = 16'h1234;
      @(negedge clk);
      chk("halt_cpu_wren", bus.mem_wren, 0);
      chk("halt_cpu_stall", bus.cpu_stall, 0);
      step();
      bus.cpu_req = 0;
      bus.dma_req = 1; bus.dma_addr = 11'h011; bus.dma_wdata = 16'h4321; bus.dma_last = 1;
      @(negedge clk);
      chk("halt_dma_wren", bus.mem_wren, 0);
      chk("halt_dma_ack", bus.dma_ack, 1);
      step();
      bus.dma_req = 0; bus.dma_last = 0; bus.halt = 0;
      @(negedge clk);
      chk("halt_ram_10", ram[11'h010], init_val('h10));
      chk("halt_ram_11", ram[11'h011], init_val('h11));
      step();

      // Upper address bits alias
      bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'hF805; bus.cpu_wdata = 16'h5555;
      @(negedge clk);
      chk("alias_addr", bus.mem_addr, 'h005);
      chk("alias_wren", bus.mem_wren, 1);
      step();
      bus.cpu_req = 0; bus.cpu_we = 0;
      @(negedge clk);
      chk("alias_ram", ram[11'h005], 16'h5555);
      step();

      // Reset in the middle of beat 3
      k = 0;
      for (int c = 0; c < 3; c++) begin
         bus.dma_req = 1; bus.dma_addr = 11'h500 + 11'(k); bus.dma_wdata = 16'hE000 + 16'(k);
         bus.dma_last = 0;
         @(negedge clk);
         if (bus.dma_ack) k++;
         if (c < 2) step();
      end
      chk("mid_beats", k, 3);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_ack", bus.dma_ack, 0);
      chk("mid_rst_wren", bus.mem_wren, 0);
      chk("mid_rst_addr", bus.mem_addr, 0);
      step();
      rst = 1'b0;
      bus.dma_req = 0;
      @(negedge clk);
      chk("mid_ram_b2", ram[11'h501], 16'hE001);
      chk("mid_ram_b3", ram[11'h502], init_val('h502));
      step();

      // After reset the beat count restarts from the first ack
      k = 0; run = 0; first_run = -1; gc = -1; cpu_pend = 0; nrv = 0;
      for (int c = 0; c < 30 && gc < 0; c++) begin
         if (c == 1) cpu_pend = 1;
         bus.dma_req = 1; bus.dma_addr = 11'h600 + 11'(k); bus.dma_wdata = 16'hF000 + 16'(k);
         bus.dma_last = 0;
         bus.cpu_req = cpu_pend; bus.cpu_we = 0; bus.cpu_addr = 16'h0050;
         @(negedge clk);
         nrv += int'(bus.cpu_rvalid);
         if (bus.dma_ack) begin
            k++;
            if (first_run < 0) run++;
         end else if (first_run < 0)
            first_run = run;
         if (cpu_pend && !bus.cpu_stall) begin
            cpu_pend = 0;
            gc = c;
         end
         step();
      end
      bus.dma_req = 0; bus.cpu_req = 0;
      chk("post_rst_run", first_run, 16);
      chk("post_rst_cpu_cycle", gc, 16);
      chk("post_rst_no_rvalid", nrv, 0);
      @(negedge clk);
      chk("post_rst_rvalid", bus.cpu_rvalid, 1);
      chk("post_rst_rdata", bus.cpu_rdata, init_val('h50));
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
